// File: rtl/sub_bytes_seq.sv
// Forward AES SubBytes engine: substitutes a 128-bit state in place, LANES bytes per beat,
// with valid/ready handshakes on input and output.
module sub_bytes_seq #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int N = 16 / LANES;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
            $error("sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    // Multiply in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Inverse as a^254 = a^2 * a^4 * ... * a^128; yields 0 for a = 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] x;
        logic [7:0] s;
        x = gf_inv(a);
        for (int i = 0; i < 8; i++) begin
            s[i] = x[i] ^ x[(i + 4) % 8] ^ x[(i + 5) % 8] ^ x[(i + 6) % 8] ^ x[(i + 7) % 8];
        end
        return s ^ 8'h63;
    endfunction

    logic [1:0]   state;
    logic [3:0]   cnt;
    logic [127:0] st;
    logic [127:0] st_nxt;
    logic         out_valid_r;

    // Byte k sits at [127-8k -: 8]; this beat covers bytes cnt*LANES .. cnt*LANES+LANES-1.
    always_comb begin
        int base;
        st_nxt = st;
        base   = 0;
        for (int l = 0; l < LANES; l++) begin
            base = 127 - 8 * (int'(cnt) * LANES + l);
            st_nxt[base -: 8] = sbox(st[base -: 8]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            st          <= 128'd0;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        st    <= in_data;
                        cnt   <= 4'd0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    st <= st_nxt;
                    if (cnt == 4'(N - 1)) begin
                        cnt         <= 4'd0;
                        state       <= DONE;
                        out_valid_r <= 1'b1;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A transfer happens on an edge where valid and ready are both high; valid never drops without ready.
    assign in_ready  = rst_n && (state == IDLE);
    assign out_valid = out_valid_r;
    assign out_data  = st;
    assign busy      = (state == BUSY) || (state == DONE);

endmodule
